// File: rtl/seg7_pkg.sv
// Shared types, segment constants and the BCD-to-segment decode function
// for the seven-segment scan driver. Segment order is {g,f,e,d,c,b,a},
// active-high.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  // Codes 10..15 are not decimal digits and render as a single dash.
  function automatic seg_t bcd_to_seg(input bcd_t bcd);
    seg_t seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load channel of the seven-segment scan driver: the producer offers a
// packed BCD word plus decimal points with a valid/ready handshake.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;

  modport master (
    output load_valid,
    output bcd_in,
    output dp_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  bcd_in,
    input  dp_in,
    output load_ready
  );

endinterface

// File: rtl/bcd_seg7_dec.sv
// Combinational BCD to seven-segment decoder, a thin wrapper so the decode
// appears once in the netlist on the currently scanned digit.
module bcd_seg7_dec
  import seg7_pkg::*;
(
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. A word accepted on the load
// channel is parked in a pending buffer and only copied into the display
// register when the scan wraps back to digit 0, so a frame never mixes
// digits of two words. Optional feature macro: SEG7_LZ_SUPPRESS_EN
// (blank leading zeros; digit 0 is always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int SEG_ACT_LOW = 0,
  parameter int AN_ACT_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg7_scan_driver_if.slave     load,
  output seg_t                  seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam bit SEG_INV = (SEG_ACT_LOW != 0);
  localparam bit AN_INV  = (AN_ACT_LOW != 0);
  localparam seg_t SEG_OFF = SEG_INV ? 7'h7F : 7'h00;
  localparam logic DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_INV ? '1 : '0;

  // Scan state
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] dig_idx_q, dig_idx_d;

  // Shadowing: pending buffer and display register
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

  // Pin-level output registers (polarity already applied)
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic tick, wrap, commit, xfer;
  bcd_t digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS-1:0] blank_mask;
  bcd_t cur_bcd;
  logic cur_dp, cur_blank;
  seg_t dec_seg, seg_raw;

  assign tick   = enable && (div_cnt_q == DIV_LAST);
  assign wrap   = tick && (dig_idx_q == IDX_LAST);
  // ready is low whenever a word is pending, so a commit cycle can never
  // also be a transfer cycle.
  assign commit = wrap && pending_q;
  assign xfer   = load.load_valid && !pending_q;
  assign load.load_ready = !pending_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = disp_bcd_q[4*gi +: 4];
      assign an_sel[gi]    = (dig_idx_q == IDX_W'(gi));
    end
  endgenerate

`ifdef SEG7_LZ_SUPPRESS_EN
  // A digit above 0 is blank when it and every digit above it are zero.
  assign blank_mask[0] = 1'b0;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign blank_mask[gi] = (digit_arr[gi] == 4'd0);
      end else begin : g_mid
        assign blank_mask[gi] = (digit_arr[gi] == 4'd0) && blank_mask[gi+1];
      end
    end
  endgenerate
`else
  assign blank_mask = '0;
`endif

  // Select the digit, decimal point and blank flag of the scanned position
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx_q == IDX_W'(k)) begin
        cur_bcd   = digit_arr[k];
        cur_dp    = disp_dp_q[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  bcd_seg7_dec u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  // Next-state for scan counters, handshake buffers and output registers
  always_comb begin
    div_cnt_d  = div_cnt_q;
    dig_idx_d  = dig_idx_q;
    pending_d  = pending_q;
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    disp_bcd_d = disp_bcd_q;
    disp_dp_d  = disp_dp_q;
    seg_raw    = cur_blank ? SEG_BLANK : dec_seg;

    if (tick) begin
      div_cnt_d = '0;
      dig_idx_d = wrap ? '0 : dig_idx_q + 1'b1;
    end else if (enable) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (commit) begin
      disp_bcd_d = pend_bcd_q;
      disp_dp_d  = pend_dp_q;
      pending_d  = 1'b0;
    end else if (xfer) begin
      pend_bcd_d = load.bcd_in;
      pend_dp_d  = load.dp_in;
      pending_d  = 1'b1;
    end

    if (enable) begin
      an_d  = AN_INV ? ~an_sel : an_sel;
      seg_d = SEG_INV ? ~seg_raw : seg_raw;
      dp_d  = cur_dp ^ SEG_INV;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
    end
    frame_d = wrap;
  end

  // State update; reset returns to digit 0 with everything dark and the
  // pending word discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      dig_idx_q  <= '0;
      pending_q  <= 1'b0;
      pend_bcd_q <= '0;
      pend_dp_q  <= '0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
      frame_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      dig_idx_q  <= dig_idx_d;
      pending_q  <= pending_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit active-high instance, a
// 4-digit active-low instance driven in lockstep, and a 1-digit instance.
// Expectations depend on SEG7_LZ_SUPPRESS_EN when it is defined.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        lv = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dpv = '0;
  logic        lv1 = 1'b0;
  logic [3:0]  bcd1 = '0;
  logic        dp1v = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) if_main ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) if_inv ();
  seg7_scan_driver_if #(.NUM_DIGITS(1)) if_one ();

  assign if_main.load_valid = lv;
  assign if_main.bcd_in     = bcd;
  assign if_main.dp_in      = dpv;
  assign if_inv.load_valid  = lv;
  assign if_inv.bcd_in      = bcd;
  assign if_inv.dp_in       = dpv;
  assign if_one.load_valid  = lv1;
  assign if_one.bcd_in      = bcd1;
  assign if_one.dp_in       = dp1v;

  logic [6:0] seg, seg_inv, seg1;
  logic       dp, dp_inv, dp1;
  logic [3:0] an, an_inv;
  logic [0:0] an1;
  logic       frame, frame_inv, frame1;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .load(if_main),
    .seg_o(seg), .dp_o(dp), .an_o(an), .frame_o(frame));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .enable(en), .load(if_inv),
    .seg_o(seg_inv), .dp_o(dp_inv), .an_o(an_inv), .frame_o(frame_inv));

  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(4), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) dut_one (
    .clk(clk), .rst_n(rst_n), .enable(en), .load(if_one),
    .seg_o(seg1), .dp_o(dp1), .an_o(an1), .frame_o(frame1));

`ifdef SEG7_LZ_SUPPRESS_EN
  localparam logic [27:0] EXP_0040 = {7'h00, 7'h00, 7'h66, 7'h3F};
  localparam logic [27:0] EXP_0000 = {7'h00, 7'h00, 7'h00, 7'h3F};
`else
  localparam logic [27:0] EXP_0040 = {7'h3F, 7'h3F, 7'h66, 7'h3F};
  localparam logic [27:0] EXP_0000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: %0h ok", tag, got);
    end
  endtask

  // Wait for a frame pulse that follows a commit (ready high again).
  task automatic wait_frame(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame && if_main.load_ready) break;
    end
    chk({tag, " frame seen"}, {31'd0, frame && if_main.load_ready}, 32'd1);
  endtask

  // Called at the frame negedge; digit k is visible 1+4k cycles later.
  task automatic check_digits(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 4) @(negedge clk);
      exp_an  = 4'b0001 << k;
      exp_seg = segs[7*k +: 7];
      exp_dp  = dps[k];
      chk($sformatf("%s d%0d an", tag, k), {28'd0, an}, {28'd0, exp_an});
      chk($sformatf("%s d%0d seg", tag, k), {25'd0, seg}, {25'd0, exp_seg});
      chk($sformatf("%s d%0d dp", tag, k), {31'd0, dp}, {31'd0, exp_dp});
      chk($sformatf("%s d%0d inv an", tag, k), {28'd0, an_inv}, {28'd0, ~exp_an});
      chk($sformatf("%s d%0d inv seg", tag, k), {25'd0, seg_inv}, {25'd0, ~exp_seg});
      chk($sformatf("%s d%0d inv dp", tag, k), {31'd0, dp_inv}, {31'd0, ~exp_dp});
    end
  endtask

  task automatic load_word(input logic [15:0] w, input logic [3:0] d);
    lv  = 1'b1;
    bcd = w;
    dpv = d;
    @(negedge clk);
    lv = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst an", {28'd0, an}, 32'h0);
    chk("rst seg", {25'd0, seg}, 32'h0);
    chk("rst dp", {31'd0, dp}, 32'h0);
    chk("rst frame", {31'd0, frame}, 32'h0);
    chk("rst ready", {31'd0, if_main.load_ready}, 32'h1);
    chk("rst inv an", {28'd0, an_inv}, 32'hF);
    chk("rst inv seg", {25'd0, seg_inv}, 32'h7F);
    chk("rst inv dp", {31'd0, dp_inv}, 32'h1);
    chk("rst one an", {31'd0, an1}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start an", {28'd0, an}, 32'h1);
    chk("start seg", {25'd0, seg}, 32'h3F);

    // Load 1234 and hold off until the wrap
    load_word(16'h1234, 4'b0100);
    chk("1234 ready low", {31'd0, if_main.load_ready}, 32'h0);
    wait_frame("1234");
    check_digits("1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100);

    // Non-decimal code shows a dash
    load_word(16'h1A23, 4'b0000);
    wait_frame("1A23");
    check_digits("1A23", {7'h06, 7'h40, 7'h5B, 7'h4F}, 4'b0000);

    // Back-to-back loads with valid held high
    lv  = 1'b1;
    bcd = 16'h5678;
    dpv = 4'b0001;
    @(negedge clk);
    bcd = 16'h9999;
    dpv = 4'b1000;
    chk("b2b ready low", {31'd0, if_main.load_ready}, 32'h0);
    wait_frame("5678");
    check_digits("5678", {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0001);
    chk("b2b second pending", {31'd0, if_main.load_ready}, 32'h0);
    lv = 1'b0;
    wait_frame("9999");
    check_digits("9999", {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 4'b1000);

    // enable low for 10 cycles: dark, counters hold, resume on same digit
    wait_frame("en");
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en off an", {28'd0, an}, 32'h0);
    chk("en off inv an", {28'd0, an_inv}, 32'hF);
    repeat (9) @(negedge clk);
    chk("en off an late", {28'd0, an}, 32'h0);
    en = 1'b1;
    @(negedge clk);
    chk("en resume an", {28'd0, an}, 32'h1);
    chk("en resume seg", {25'd0, seg}, 32'h6F);
    @(negedge clk);
    chk("en held digit", {28'd0, an}, 32'h1);
    @(negedge clk);
    chk("en next digit", {28'd0, an}, 32'h2);

    // Leading zeros
    load_word(16'h0040, 4'b0000);
    wait_frame("0040");
    check_digits("0040", EXP_0040, 4'b0000);
    load_word(16'h0000, 4'b0000);
    wait_frame("0000");
    check_digits("0000", EXP_0000, 4'b0000);

    // Asynchronous reset mid-scan with a word pending
    load_word(16'h8888, 4'b1111);
    chk("pre-rst ready", {31'd0, if_main.load_ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst an", {28'd0, an}, 32'h0);
    chk("arst seg", {25'd0, seg}, 32'h0);
    chk("arst ready", {31'd0, if_main.load_ready}, 32'h1);
    chk("arst frame", {31'd0, frame}, 32'h0);
    chk("arst inv an", {28'd0, an_inv}, 32'hF);
    chk("arst inv seg", {25'd0, seg_inv}, 32'h7F);
    chk("arst inv frame", {31'd0, frame_inv}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst an", {28'd0, an}, 32'h1);
    chk("post-rst seg", {25'd0, seg}, 32'h3F);
    wait_frame("post-rst");
    check_digits("post-rst", EXP_0000, 4'b0000);

    // Single digit: frame every SCAN_DIV cycles
    lv1 = 1'b1;
    bcd1 = 4'h7;
    dp1v = 1'b1;
    @(negedge clk);
    lv1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame1 && if_one.load_ready) break;
    end
    chk("one frame seen", {31'd0, frame1 && if_one.load_ready}, 32'h1);
    @(negedge clk);
    chk("one an", {31'd0, an1}, 32'h1);
    chk("one seg", {25'd0, seg1}, 32'h07);
    chk("one dp", {31'd0, dp1}, 32'h1);
    for (int p = 0; p < 2; p++) begin
      n = (p == 0) ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        n++;
        if (frame1) break;
      end
      chk($sformatf("one period %0d", p), n, 32'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
